// File: rtl/tpu_pkg.sv
// tpu_pkg: shared definitions for the TPU command sequencer.
//   - ADDR_W / TILE_W / ERR_W   : field widths of a matmul command
//   - S_* / seq_state_e         : sequencer state encoding
//   - ERR_*                     : err_code values reported on a timeout
//   - rep_addr_width()          : width of a per-column replicated address bus
//   - err_code_of()             : maps a timed-out wait state to its err_code
package tpu_pkg;

  localparam int ADDR_W = 8;
  localparam int TILE_W = 4;
  localparam int ERR_W  = 3;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FILL      = 3'd1;
  localparam logic [2:0] S_WAIT_FILL = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_COMPUTE   = 3'd4;
  localparam logic [2:0] S_WAIT_OUT  = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ERROR     = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_FILL      = S_FILL,
    ST_WAIT_FILL = S_WAIT_FILL,
    ST_DRAIN     = S_DRAIN,
    ST_COMPUTE   = S_COMPUTE,
    ST_WAIT_OUT  = S_WAIT_OUT,
    ST_DONE      = S_DONE,
    ST_ERROR     = S_ERROR
  } seq_state_e;

  localparam logic [ERR_W-1:0] ERR_NONE      = 3'd0;
  localparam logic [ERR_W-1:0] ERR_WAIT_FILL = 3'd1;
  localparam logic [ERR_W-1:0] ERR_DRAIN     = 3'd2;
  localparam logic [ERR_W-1:0] ERR_WAIT_OUT  = 3'd3;

  // One ADDR_W-bit address per array column.
  function automatic int rep_addr_width(input int width_height);
    return width_height * ADDR_W;
  endfunction

  function automatic logic [ERR_W-1:0] err_code_of(input seq_state_e s);
    logic [ERR_W-1:0] code;
    case (s)
      ST_WAIT_FILL: code = ERR_WAIT_FILL;
      ST_DRAIN:     code = ERR_DRAIN;
      ST_WAIT_OUT:  code = ERR_WAIT_OUT;
      default:      code = ERR_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// seq_timeout_counter: counts cycles spent in a wait state.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   clear   : restart the count at 0 on the next cycle (state change)
//   en      : the sequencer is in a wait state this cycle
//   expired : en is high and this is cycle TIMEOUT_CYCLES-1 of the wait
module seq_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The count saturates at LAST so it cannot wrap if the owner lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/tpu_sequencer.sv
// tpu_sequencer: accepts one matmul command and drives the TPU top level
// through weight load (fill pulse, drain level) and one active pulse per tile,
// waiting on the top level's done flags between steps.
//   clk, reset (async active-low)
//   cmd_*            : command handshake and fields (valid/ready)
//   abort            : synchronous abort back to IDLE
//   mem_to_fifo_done, fifo_to_arr_done, output_done : level done flags
//   *Mem_*_addr_base : current bases, replicated once per array column
//   fill_fifo, drain_fifo, active : TPU control strobes
//   busy, done, error, err_code   : status
// Every output is a register loaded from the next state, so each output is
// aligned with the state the machine is in during that cycle.
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int WIDTH_HEIGHT   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ADDR_W-1:0]              cmd_weight_base,
  input  logic [ADDR_W-1:0]              cmd_input_base,
  input  logic [ADDR_W-1:0]              cmd_output_base,
  input  logic [TILE_W-1:0]              cmd_tiles_m1,
  input  logic                           cmd_skip_weights,
  input  logic                           abort,
  input  logic                           mem_to_fifo_done,
  input  logic                           fifo_to_arr_done,
  input  logic                           output_done,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] weightMem_rd_addr_base,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] inputMem_rd_addr_base,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] outputMem_wr_addr_base,
  output logic                           fill_fifo,
  output logic                           drain_fifo,
  output logic                           active,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [ERR_W-1:0]               err_code
);

  localparam int BUS_W = rep_addr_width(WIDTH_HEIGHT);
  // Per-tile stride; the cast keeps it modulo 256 like the address itself.
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WIDTH_HEIGHT);

  seq_state_e state_q, state_d;

  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [ADDR_W-1:0] ibase_q, ibase_d;
  logic [ADDR_W-1:0] obase_q, obase_d;
  logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             fill_q, fill_d;
  logic             drain_q, drain_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] err_code_q, err_code_d;

  logic timed_out;
  logic tmo_clear;
  logic tmo_en;
  logic tmo_expired;

  // Any state change restarts the wait counter, so each wait state (including
  // every re-entry of WAIT_OUT between tiles) starts from zero.
  assign tmo_clear = (state_d != state_q);
  assign tmo_en    = (state_q == ST_WAIT_FILL) || (state_q == ST_DRAIN) ||
                     (state_q == ST_WAIT_OUT);

  seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    wbase_d    = wbase_q;
    ibase_d    = ibase_q;
    obase_d    = obase_q;
    tile_cnt_d = tile_cnt_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    timed_out  = 1'b0;

    if (abort) begin
      // Abort wins over everything, including a same-cycle command.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (cmd_valid) begin
            wbase_d    = cmd_weight_base;
            ibase_d    = cmd_input_base;
            obase_d    = cmd_output_base;
            tile_cnt_d = cmd_tiles_m1;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            state_d    = cmd_skip_weights ? ST_COMPUTE : ST_FILL;
          end
        end
        ST_FILL: state_d = ST_WAIT_FILL;
        ST_WAIT_FILL: begin
          if (mem_to_fifo_done) begin
            state_d = ST_DRAIN;
          end else if (tmo_expired) begin
            timed_out = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (fifo_to_arr_done) begin
            state_d = ST_COMPUTE;
          end else if (tmo_expired) begin
            timed_out = 1'b1;
          end
        end
        ST_COMPUTE: state_d = ST_WAIT_OUT;
        ST_WAIT_OUT: begin
          if (output_done) begin
            if (tile_cnt_q != '0) begin
              tile_cnt_d = tile_cnt_q - TILE_W'(1);
              ibase_d    = ibase_q + STRIDE;
              obase_d    = obase_q + STRIDE;
              state_d    = ST_COMPUTE;
            end else begin
              state_d = ST_DONE;
            end
          end else if (tmo_expired) begin
            timed_out = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (timed_out) begin
      state_d    = ST_ERROR;
      error_d    = 1'b1;
      err_code_d = err_code_of(state_q);
    end

    // Strobes decode from the next state; an abort lands in IDLE, which
    // already forces fill/drain/active low.
    fill_d      = (state_d == ST_FILL);
    drain_d     = (state_d == ST_DRAIN);
    active_d    = (state_d == ST_COMPUTE);
    done_d      = (state_d == ST_DONE);
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_ERROR);
    busy_d      = !cmd_ready_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wbase_q     <= '0;
      ibase_q     <= '0;
      obase_q     <= '0;
      tile_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      fill_q      <= 1'b0;
      drain_q     <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      wbase_q     <= wbase_d;
      ibase_q     <= ibase_d;
      obase_q     <= obase_d;
      tile_cnt_q  <= tile_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      fill_q      <= fill_d;
      drain_q     <= drain_d;
      active_q    <= active_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign weightMem_rd_addr_base = {WIDTH_HEIGHT{wbase_q}};
  assign inputMem_rd_addr_base  = {WIDTH_HEIGHT{ibase_q}};
  assign outputMem_wr_addr_base = {WIDTH_HEIGHT{obase_q}};

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign fill_fifo  = fill_q;
  assign drain_fifo = drain_q;
  assign active     = active_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;

  // BUS_W documents the replicated bus width; tie it to the port width.
  logic unused_bus_w;
  assign unused_bus_w = (BUS_W == $bits(weightMem_rd_addr_base));

endmodule

// File: tb/tb_tpu_sequencer.sv
module tb_tpu_sequencer;

  localparam int WH = 16;
  localparam int TO = 1024;
  localparam int BW = WH * 8;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_weight_base = '0;
  logic [7:0]    cmd_input_base = '0;
  logic [7:0]    cmd_output_base = '0;
  logic [3:0]    cmd_tiles_m1 = '0;
  logic          cmd_skip_weights = 1'b0;
  logic          abort = 1'b0;
  logic          mem_to_fifo_done = 1'b0;
  logic          fifo_to_arr_done = 1'b0;
  logic          output_done = 1'b0;
  logic [BW-1:0] weightMem_rd_addr_base;
  logic [BW-1:0] inputMem_rd_addr_base;
  logic [BW-1:0] outputMem_wr_addr_base;
  logic          fill_fifo, drain_fifo, active, busy, done, error;
  logic [2:0]    err_code;

  int checks = 0;
  int passes = 0;

  // Observations of the most recent run_cmd call.
  int            obs_fills, obs_drains, obs_acts, obs_dones, obs_accepts;
  int            obs_done_at, exp_done_at;
  bit            obs_timeout;
  logic [BW-1:0] obs_in  [0:15];
  logic [BW-1:0] obs_out [0:15];
  logic [BW-1:0] obs_w   [0:15];

  tpu_sequencer #(.WIDTH_HEIGHT(WH), .TIMEOUT_CYCLES(TO)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_weight_base       (cmd_weight_base),
    .cmd_input_base        (cmd_input_base),
    .cmd_output_base       (cmd_output_base),
    .cmd_tiles_m1          (cmd_tiles_m1),
    .cmd_skip_weights      (cmd_skip_weights),
    .abort                 (abort),
    .mem_to_fifo_done      (mem_to_fifo_done),
    .fifo_to_arr_done      (fifo_to_arr_done),
    .output_done           (output_done),
    .weightMem_rd_addr_base(weightMem_rd_addr_base),
    .inputMem_rd_addr_base (inputMem_rd_addr_base),
    .outputMem_wr_addr_base(outputMem_wr_addr_base),
    .fill_fifo             (fill_fifo),
    .drain_fifo            (drain_fifo),
    .active                (active),
    .busy                  (busy),
    .done                  (done),
    .error                 (error),
    .err_code              (err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] rep(input logic [7:0] b);
    logic [BW-1:0] r;
    for (int i = 0; i < WH; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  // Issues one command and plays the TPU top level: each done flag rises a
  // fixed latency after its request was seen and stays up until the next step.
  task automatic run_cmd(input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob,
                         input logic [3:0] tm1, input logic skip,
                         input int lf, input int ld, input int lo, input bit hold_valid);
    int fill_at, drain_at, act_at;
    bit prev_busy;
    obs_fills = 0; obs_drains = 0; obs_acts = 0; obs_dones = 0; obs_accepts = 0;
    obs_done_at = -1; exp_done_at = -1; obs_timeout = 1'b1;
    fill_at = -1; drain_at = -1; act_at = -1;
    @(negedge clk);
    prev_busy = busy;
    cmd_weight_base = wb; cmd_input_base = ib; cmd_output_base = ob;
    cmd_tiles_m1 = tm1; cmd_skip_weights = skip; cmd_valid = 1'b1;
    for (int s = 0; s < BUDGET; s++) begin
      @(negedge clk);
      if (!hold_valid) cmd_valid = 1'b0;
      if (busy && !prev_busy) obs_accepts++;
      prev_busy = busy;
      if (fill_fifo) begin obs_fills++; fill_at = s; end
      if (drain_fifo) begin obs_drains++; if (drain_at < 0) drain_at = s; end
      if (active) begin
        if (obs_acts < 16) begin
          obs_in[obs_acts]  = inputMem_rd_addr_base;
          obs_out[obs_acts] = outputMem_wr_addr_base;
          obs_w[obs_acts]   = weightMem_rd_addr_base;
        end
        obs_acts++;
        act_at = s;
      end
      if (done) begin
        obs_dones++; obs_done_at = s; obs_timeout = 1'b0;
        break;
      end
      mem_to_fifo_done = (fill_at >= 0) && (drain_at < 0) && (s - fill_at >= lf);
      fifo_to_arr_done = (drain_at >= 0) && (obs_acts == 0) && (s - drain_at >= ld);
      output_done      = (act_at >= 0) && (s - act_at >= lo);
      if (output_done && (obs_acts == int'(tm1) + 1) && (exp_done_at < 0)) exp_done_at = s + 1;
    end
    mem_to_fifo_done = 1'b0; fifo_to_arr_done = 1'b0; output_done = 1'b0;
    $display("cmd w=%02h i=%02h o=%02h tiles=%0d skip=%0d: fills=%0d drains=%0d acts=%0d done_at=%0d",
             wb, ib, ob, int'(tm1) + 1, skip, obs_fills, obs_drains, obs_acts, obs_done_at);
  endtask

  // Checks the observations of the last run_cmd against the command rules.
  task automatic check_cmd(input string name, input logic [7:0] wb, input logic [7:0] ib,
                           input logic [7:0] ob, input logic [3:0] tm1, input logic skip,
                           input int ld);
    int exp_drains, n;
    exp_drains = skip ? 0 : ld + 1;
    checks++;
    if (obs_timeout !== 1'b0) $display("FAIL %s done_seen: got timeout, need done", name);
    else passes++;
    checks++;
    if (obs_fills !== (skip ? 0 : 1)) $display("FAIL %s fills: got %0d need %0d", name, obs_fills, skip ? 0 : 1);
    else passes++;
    checks++;
    if (obs_drains !== exp_drains) $display("FAIL %s drain_cycles: got %0d need %0d", name, obs_drains, exp_drains);
    else passes++;
    checks++;
    if (obs_acts !== int'(tm1) + 1) $display("FAIL %s actives: got %0d need %0d", name, obs_acts, int'(tm1) + 1);
    else passes++;
    checks++;
    if (obs_done_at !== exp_done_at) $display("FAIL %s done_cycle: got %0d need %0d", name, obs_done_at, exp_done_at);
    else passes++;
    n = (obs_acts < 16) ? obs_acts : 16;
    for (int k = 0; k < n; k++) begin
      logic [7:0] ei, eo;
      ei = 8'((int'(ib) + WH * k) % 256);
      eo = 8'((int'(ob) + WH * k) % 256);
      checks++;
      if (obs_in[k] !== rep(ei) || obs_out[k] !== rep(eo) || obs_w[k] !== rep(wb))
        $display("FAIL %s addr_tile%0d: got i=%h o=%h w=%h need i=%02h o=%02h w=%02h",
                 name, k, obs_in[k][7:0], obs_out[k][7:0], obs_w[k][7:0], ei, eo, wb);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL %s idle_after: got busy=%b ready=%b done=%b need 0 1 0", name, busy, cmd_ready, done);
    else passes++;
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || fill_fifo !== 1'b0 || drain_fifo !== 1'b0 ||
        active !== 1'b0 || done !== 1'b0 || error !== 1'b0 || err_code !== 3'd0 ||
        weightMem_rd_addr_base !== '0 || inputMem_rd_addr_base !== '0 || outputMem_wr_addr_base !== '0)
      $display("FAIL %s: got ready=%b busy=%b fill=%b drain=%b act=%b done=%b err=%b code=%0d w=%h i=%h need reset values",
               name, cmd_ready, busy, fill_fifo, drain_fifo, active, done, error, err_code,
               weightMem_rd_addr_base[7:0], inputMem_rd_addr_base[7:0]);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_initial");
    reset = 1'b1;
    // Start a command and kill it mid-flight with the asynchronous reset.
    @(negedge clk);
    cmd_weight_base = 8'h5A; cmd_input_base = 8'h33; cmd_output_base = 8'h44;
    cmd_tiles_m1 = 4'd3; cmd_skip_weights = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    mem_to_fifo_done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_pre_busy: got %b need 1", busy);
    else passes++;
    #2 reset = 1'b0;
    #1 check_reset_values("reset_async_midop");
    mem_to_fifo_done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cmd_weight_base = 8'h11; cmd_tiles_m1 = 4'd0; cmd_skip_weights = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || active !== 1'b1)
      $display("FAIL reset_first_accept: got busy=%b ready=%b act=%b need 1 0 1", busy, cmd_ready, active);
    else passes++;
    output_done = 1'b1;
    repeat (3) @(negedge clk);
    output_done = 1'b0;
    $display("reset test: release and first accept done");
  endtask

  task automatic test_weight_load();
    run_cmd(8'h20, 8'h20, 8'h20, 4'd0, 1'b0, 16, 16, 16, 1'b0);
    check_cmd("load_fixed", 8'h20, 8'h20, 8'h20, 4'd0, 1'b0, 16);
    for (int r = 0; r < 3; r++) begin
      logic [7:0] wb, ib, ob;
      logic [3:0] tm1;
      logic skip;
      int lf, ld, lo;
      wb = 8'($urandom); ib = 8'($urandom); ob = 8'($urandom);
      tm1 = 4'($urandom_range(0, 15)); skip = 1'($urandom);
      lf = $urandom_range(0, 20); ld = $urandom_range(0, 20); lo = $urandom_range(1, 20);
      run_cmd(wb, ib, ob, tm1, skip, lf, ld, lo, 1'b0);
      check_cmd("load_random", wb, ib, ob, tm1, skip, ld);
    end
  endtask

  task automatic test_skip_tiles();
    run_cmd(8'h77, 8'h00, 8'h80, 4'd2, 1'b1, 0, 0, 5, 1'b0);
    check_cmd("skip_3tiles", 8'h77, 8'h00, 8'h80, 4'd2, 1'b1, 0);
    run_cmd(8'h01, 8'hF8, 8'hF0, 4'd1, 1'b1, 0, 0, 3, 1'b0);
    check_cmd("skip_wrap", 8'h01, 8'hF8, 8'hF0, 4'd1, 1'b1, 0);
    checks++;
    if (obs_in[1] !== rep(8'h08)) $display("FAIL wrap_input: got %h need 08", obs_in[1][7:0]);
    else passes++;
  endtask

  // Counts wait-state cycles after the trigger strobe until error rises.
  task automatic test_timeout();
    int n;
    bit seen, got;
    for (int pass = 0; pass < 2; pass++) begin
      logic [2:0] ecode;
      ecode = (pass == 0) ? 3'd1 : 3'd3;
      n = 0; seen = 1'b0; got = 1'b0;
      @(negedge clk);
      cmd_weight_base = 8'h0C; cmd_input_base = 8'h0D; cmd_output_base = 8'h0E;
      cmd_tiles_m1 = 4'd0; cmd_skip_weights = (pass == 1); cmd_valid = 1'b1;
      for (int s = 0; s < TO + 100; s++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        if (s == 0) begin
          checks++;
          if (error !== 1'b0) $display("FAIL timeout_clear_on_accept: got %b need 0", error);
          else passes++;
        end
        if (error) begin got = 1'b1; break; end
        if (seen) n++;
        if ((pass == 0 && fill_fifo) || (pass == 1 && active)) seen = 1'b1;
      end
      checks++;
      if (!got || n !== TO) $display("FAIL timeout_cycles: got error=%b after %0d cycles need 1 after %0d", got, n, TO);
      else passes++;
      checks++;
      if (err_code !== ecode || busy !== 1'b0 || cmd_ready !== 1'b1)
        $display("FAIL timeout_status: got code=%0d busy=%b ready=%b need %0d 0 1", err_code, busy, cmd_ready, ecode);
      else passes++;
      $display("timeout test: code=%0d after %0d wait cycles", err_code, n);
    end
    run_cmd(8'h42, 8'h43, 8'h44, 4'd0, 1'b0, 2, 3, 4, 1'b0);
    check_cmd("after_error", 8'h42, 8'h43, 8'h44, 4'd0, 1'b0, 3);
    checks++;
    if (error !== 1'b0 || err_code !== 3'd0) $display("FAIL error_cleared: got err=%b code=%0d need 0 0", error, err_code);
    else passes++;
  endtask

  task automatic test_abort();
    int drains;
    bit reached, saw_done;
    drains = 0; reached = 1'b0; saw_done = 1'b0;
    @(negedge clk);
    cmd_weight_base = 8'hA0; cmd_input_base = 8'hA1; cmd_output_base = 8'hA2;
    cmd_tiles_m1 = 4'd0; cmd_skip_weights = 1'b0; cmd_valid = 1'b1;
    for (int s = 0; s < 100; s++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      mem_to_fifo_done = 1'b1;
      if (drain_fifo) drains++;
      if (drains == 3) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) $display("FAIL abort_reach_drain: got %0d drain cycles need 3", drains);
    else passes++;
    abort = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0; mem_to_fifo_done = 1'b0;
    checks++;
    if (drain_fifo !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || error !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_drain: got drain=%b busy=%b ready=%b err=%b done=%b need 0 0 1 0 0",
               drain_fifo, busy, cmd_ready, error, done);
    else passes++;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) $display("FAIL abort_quiet: got done/busy after abort need none");
    else passes++;
    // Abort in IDLE together with cmd_valid: the command must be dropped.
    abort = 1'b1; cmd_valid = 1'b1; cmd_skip_weights = 1'b1;
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || active !== 1'b0) $display("FAIL abort_with_valid: got busy=%b act=%b need 0 0", busy, active);
    else passes++;
    $display("abort test: drain aborted, idle abort with valid dropped");
  endtask

  task automatic test_back_to_back();
    bit got;
    got = 1'b0;
    run_cmd(8'h30, 8'h31, 8'h32, 4'd1, 1'b1, 0, 0, 4, 1'b1);
    checks++;
    if (obs_accepts !== 1 || obs_dones !== 1)
      $display("FAIL b2b_single_accept: got accepts=%0d dones=%0d need 1 1", obs_accepts, obs_dones);
    else passes++;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_idle: got ready=%b busy=%b need 1 0", cmd_ready, busy);
    else passes++;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || active !== 1'b1) $display("FAIL b2b_second_accept: got busy=%b act=%b need 1 1", busy, active);
    else passes++;
    output_done = 1'b1;
    for (int s = 0; s < 50; s++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    output_done = 1'b0;
    checks++;
    if (!got) $display("FAIL b2b_second_done: got no done need done");
    else passes++;
    @(negedge clk);
    $display("back-to-back test: second command completed=%0d", got);
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_skip_tiles();
    test_timeout();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
- Command-driven controller directly upstream of the TPU top level.
- Accepts one matmul command: weight, input and output base addresses, a tile count, and a weight-reuse flag.
- Drives the weight-load sequence in order: fill_fifo pulse, then drain_fifo level, then active pulse. Waits on the top level's done flags between steps.
- Replaces the hand-timed delays software would otherwise need, and reports busy, done and timeout errors.

Parameters:
- WIDTH_HEIGHT, 16: array dimension; sets the replication of the address buses and the per-tile address stride.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in any wait state before an error is flagged.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (IDLE or ERROR).
- cmd_weight_base  in  8  weight memory read base.
- cmd_input_base  in  8  input memory read base for tile 0.
- cmd_output_base  in  8  output memory write base for tile 0.
- cmd_tiles_m1  in  4  number of tiles minus 1 (1..16 tiles).
- cmd_skip_weights  in  1  reuse the weights already in the array; skip fill/drain.
- abort  in  1  synchronous abort; returns to IDLE.
- mem_to_fifo_done  in  1  weight FIFOs filled (level).
- fifo_to_arr_done  in  1  weights shifted into the array (level).
- output_done  in  1  tile results written to output memory (level).
- weightMem_rd_addr_base  out  WIDTH_HEIGHT*8  weight base replicated per column.
- inputMem_rd_addr_base  out  WIDTH_HEIGHT*8  current input base replicated per column.
- outputMem_wr_addr_base  out  WIDTH_HEIGHT*8  current output base replicated per column.
- fill_fifo  out  1  one-cycle pulse.
- drain_fifo  out  1  level.
- active  out  1  one-cycle pulse per tile.
- busy  out  1  high in every state except IDLE and ERROR.
- done  out  1  one-cycle pulse at command completion.
- error  out  1  sticky timeout flag.
- err_code  out  3  encoding of the state that timed out.

Behaviour:
- All outputs are registered (Moore).
- Reset values: state IDLE; cmd_ready=1; all other outputs 0; address registers 0.
- States: IDLE, FILL, WAIT_FILL, DRAIN, COMPUTE, WAIT_OUT, DONE, ERROR.
- Accept at the edge where cmd_valid & cmd_ready.
  - Latch all command fields.
  - Clear error and err_code.
  - tile_cnt <= cmd_tiles_m1.
  - Next state is FILL, or COMPUTE if cmd_skip_weights=1.
- FILL: fill_fifo=1 for exactly this cycle, then WAIT_FILL.
- WAIT_FILL: mem_to_fifo_done is sampled every cycle, including the entry cycle; when high, go to DRAIN.
- DRAIN: drain_fifo=1 continuously while in this state. At the edge where fifo_to_arr_done=1, go to COMPUTE; drain_fifo is 0 from the next cycle.
- COMPUTE: active=1 for exactly one cycle, then WAIT_OUT.
- WAIT_OUT: on output_done=1:
  - If tile_cnt != 0: decrement tile_cnt, add WIDTH_HEIGHT (mod 256) to the input and output bases, go to COMPUTE. Weights are not reloaded.
  - Otherwise: go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address outputs hold stable from acceptance until the next accept. The weight base never changes within a command.
- Timeout:
  - The counter clears on entry to each of WAIT_FILL, DRAIN and WAIT_OUT.
  - Reaching TIMEOUT_CYCLES-1 with no done flag means: go to ERROR, error=1, err_code = state code, drain_fifo dropped.
  - ERROR keeps cmd_ready=1; a new accepted command clears error.
- abort:
  - Takes priority over every transition.
  - Any state goes to IDLE next cycle; fill_fifo, drain_fifo and active are forced to 0.
  - Does not set error; no done pulse.
  - cmd_valid in the same cycle as abort is ignored.
- cmd_valid while busy: ignored; cmd_ready=0.
- Done flags arriving outside their wait state are ignored.
- Asynchronous reset mid-operation: all outputs go to reset values immediately.

Decomposition:
- Shared package (tpu_pkg): state encoding localparams, err_code values (WAIT_FILL=1, DRAIN=2, WAIT_OUT=3), and the address-replication width helper.
- One sub-module: seq_timeout_counter. Ports clk, reset, clear, en, expired; parameter TIMEOUT_CYCLES.

Test Plan:
1. Reset low during operation, then release.
   - Outputs match reset values and cmd_ready=1.
   - A command issued after release is accepted on the first cycle.
2. Command: weight base 0x20, input base 0x20, output base 0x20, cmd_tiles_m1=0; done flags asserted 16 cycles after each request.
   - weightMem_rd_addr_base = 0x2020…20.
   - fill_fifo is a single pulse.
   - drain_fifo is high for exactly 17 cycles.
   - One active pulse.
   - done pulses one cycle after output_done is sampled.
3. cmd_tiles_m1=2, input base 0x00, cmd_skip_weights=1.
   - No fill_fifo or drain_fifo activity.
   - Three active pulses.
   - inputMem_rd_addr_base steps 0x00, 0x10, 0x20 per column byte.
   - Input base 0xF8 with one extra tile wraps to 0x08.
4. mem_to_fifo_done held low.
   - error=1 and err_code=1 after TIMEOUT_CYCLES cycles; busy=0.
   - A new command clears error.
5. abort asserted during DRAIN.
   - drain_fifo=0 and state IDLE next cycle; no done pulse; error=0.
6. cmd_valid held high while busy.
   - No second accept until done.
   - A back-to-back command is accepted in the cycle after DONE.
